daojishi: RTL and testbench
===========================

# daojishi

Two-digit BCD countdown timer for the washer program phases. It loads a preset time and counts down one unit per prescaled tick while running, with pause and resume. It presents the remaining time as tens/ones BCD digits that directly drive the seven-segment multiplexer's `code1`/`code2` inputs, and it pulses `done` for the washer controller when the count reaches 00.

## Interface
Parameters:
- `TICKDIV`, default 50000000: clock cycles per countdown unit; legal range 2 or more.

Ports:
- `clock`  in  1  system clock; the only clock in the block.
- `reset`  in  1  synchronous, active-high reset.
- `settime`  in  8  preset time in BCD, `{tens[7:4], ones[3:0]}`.
- `load`  in  1  level, sampled each edge: copy `settime` into the counter.
- `start`  in  1  level, sampled each edge: begin or resume counting.
- `pause`  in  1  level, sampled each edge: suspend counting.
- `code1`  out  4  tens digit of remaining time, BCD, registered; connects to the display stage `code1`.
- `code2`  out  4  ones digit of remaining time, BCD, registered; connects to the display stage `code2`.
- `running`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when the count reaches 00.

## Operation
States:
- **IDLE**: holds the count. `load` goes to IDLE with the new value. `start` with count ≠ 00 goes to RUN. `start` with count = 00 is ignored.
- **RUN**: the prescaler counts. On each tick the count decrements. `pause` goes to PAUSE.
- **PAUSE**: the count and prescaler both hold. `start` goes to RUN and the prescaler resumes from its held value. `load` goes to IDLE with the new value (abort).
- **DONE**: the count is 00. `load` goes to IDLE with the new value. `start` and `pause` are ignored.

Input priority, evaluated per edge: `reset` > `load` > `pause` > `start`.
- `load` is ignored in RUN.
- `start` and `pause` asserted together in RUN: pause wins.
- `start` and `pause` asserted together in PAUSE: the block stays in PAUSE.

Load clamp: a `settime` nibble greater than 9 loads as 9, independently per digit. For example, 8'hA3 loads 93 and 8'h5F loads 59.

Prescaler: counts 0..TICKDIV-1 in RUN only.
- A tick occurs in the cycle the prescaler equals TICKDIV-1; the prescaler then wraps to 0.
- The prescaler clears to 0 on reset, on load, and on entering DONE.

BCD decrement per tick:
- If ones ≠ 0: ones−1.
- Otherwise: ones ← 9 and tens ← tens−1.
- Example: 40 → 39; 10 → 09; 01 → 00.
- The count never goes below 00, so there is no wrap-around to 99.

Terminal condition: the tick that takes the count 01 → 00 also moves the state to DONE and asserts `done` on that same edge.

Outputs:
- `code1` and `code2` are the count registers themselves. They are always valid BCD (0–9).
- `running` = (state == RUN).

## Timing
Reset values: state IDLE, count 00 (`code1`=0, `code2`=0), prescaler 0, `running`=0, `done`=0.

Latencies, all relative to the sampling edge:
- `load`: the new digits appear on `code1`/`code2` after that edge; latency 1.
- `start` with count ≠ 00: `running`=1 after that edge. The first decrement occurs TICKDIV cycles later when starting from a fresh prescaler.
- `pause`: `running`=0 after that edge. A tick coinciding with `pause` is discarded, and the prescaler holds at TICKDIV-1. On resume, the next tick occurs 1 cycle after RUN is re-entered.
- `done`: high for exactly 1 cycle, on the edge where the count becomes 00. `running` drops on that same edge.

Reset asserted mid-RUN or mid-PAUSE returns everything to reset values on the next edge, with no `done` pulse.

Full run: from loaded N (decimal) to `done` takes N×TICKDIV cycles of RUN time.

## Test plan
1. Reset, then `load` with `settime`=8'h12, then a 1-cycle `start`, with TICKDIV=4:
   - `code1`/`code2` step 1/2 → 1/1 → 1/0 → 0/9 … → 0/0, one step every 4 cycles.
   - `done` pulses once, 48 cycles after entering RUN; `running`=0 afterwards.
2. `settime`=8'hAF with `load` → count reads 9/9. `settime`=8'h00, `load`, `start` → stays IDLE, `running`=0, no `done`.
3. RUN from 8'h05, `pause` after 6 cycles:
   - The count holds for 20 cycles and the prescaler holds.
   - `start` resumes, and the remaining ticks keep the original phase: total RUN cycles to `done` = 20.
4. `start` and `pause` asserted together in RUN → PAUSE. `load` asserted in RUN → ignored, count continues. `load` with 8'h30 in PAUSE → IDLE, count 3/0.
5. Reset asserted mid-RUN at count 07 → next edge count 00, IDLE, `running`=0, `done`=0. A later `start` is ignored.
6. Count reaches 00 (DONE). `start` → ignored. `load` with 8'h01 → IDLE, count 0/1. `start` → `done` fires after TICKDIV cycles.

Source files
------------

// File: rtl/daojishi_if.sv
// rtl/daojishi_if.sv - control and display signals of the daojishi countdown timer
interface daojishi_if;
   logic [7:0] settime;
   logic       load;
   logic       start;
   logic       pause;
   logic [3:0] code1;
   logic [3:0] code2;
   logic       running;
   logic       done;

   modport master (
      output settime, load, start, pause,
      input  code1, code2, running, done
   );

   modport slave (
      input  settime, load, start, pause,
      output code1, code2, running, done
   );
endinterface

// File: rtl/daojishi.sv
// rtl/daojishi.sv - two-digit BCD countdown timer with prescaler, pause/resume and done pulse
module daojishi #(
   parameter int unsigned TICKDIV = 50000000
) (
   input logic       clock,
   input logic       reset,
   daojishi_if.slave bus
);
   localparam int unsigned PW = (TICKDIV > 2) ? $clog2(TICKDIV) : 1;
   localparam logic [PW-1:0] TICK_LAST = PW'(TICKDIV - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;

   state_t        state, state_next;
   logic [3:0]    tens, tens_next;
   logic [3:0]    ones, ones_next;
   logic [PW-1:0] presc, presc_next;
   logic          done_r, done_next;
   logic [3:0]    load_tens, load_ones;
   logic          is_zero;

   assign load_tens = (bus.settime[7:4] > 4'd9) ? 4'd9 : bus.settime[7:4];
   assign load_ones = (bus.settime[3:0] > 4'd9) ? 4'd9 : bus.settime[3:0];
   assign is_zero   = (tens == 4'd0) && (ones == 4'd0);

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= ST_IDLE;
         tens   <= 4'd0;
         ones   <= 4'd0;
         presc  <= '0;
         done_r <= 1'b0;
      end else begin
         state  <= state_next;
         tens   <= tens_next;
         ones   <= ones_next;
         presc  <= presc_next;
         done_r <= done_next;
      end
   end

   always_comb begin
      state_next = state;
      tens_next  = tens;
      ones_next  = ones;
      presc_next = presc;
      done_next  = 1'b0;
      // load aborts from any state except RUN, where it is ignored
      if (bus.load && (state != ST_RUN)) begin
         state_next = ST_IDLE;
         tens_next  = load_tens;
         ones_next  = load_ones;
         presc_next = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start && !is_zero) state_next = ST_RUN;
            end
            ST_RUN: begin
               // a tick landing on a pause edge is dropped; prescaler stays at TICK_LAST
               if (bus.pause) begin
                  state_next = ST_PAUSE;
               end else if (presc == TICK_LAST) begin
                  presc_next = '0;
                  if (ones != 4'd0) begin
                     ones_next = ones - 4'd1;
                  end else begin
                     ones_next = 4'd9;
                     tens_next = tens - 4'd1;
                  end
                  if ((tens == 4'd0) && (ones == 4'd1)) begin
                     state_next = ST_DONE;
                     done_next  = 1'b1;
                  end
               end else begin
                  presc_next = presc + 1'b1;
               end
            end
            ST_PAUSE: begin
               if (!bus.pause && bus.start) state_next = ST_RUN;
            end
            ST_DONE: begin
               presc_next = '0;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   assign bus.code1   = tens;
   assign bus.code2   = ones;
   assign bus.running = (state == ST_RUN);
   assign bus.done    = done_r;
endmodule

// File: tb/tb_daojishi.sv
// tb/tb_daojishi.sv - self-checking bench for daojishi against a remaining-cycles model
module tb_daojishi;
   localparam int T = 4;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   daojishi_if bus();
   daojishi #(.TICKDIV(T)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

   int checks = 0;
   int errors = 0;
   int m_rem  = 0;
   int m_mode = M_IDLE;
   int m_done = 0;
   int run_edges = 0;

   function automatic int clamp_val(input logic [7:0] s);
      int t, o;
      t = (s[7:4] > 4'd9) ? 9 : int'(s[7:4]);
      o = (s[3:0] > 4'd9) ? 9 : int'(s[3:0]);
      return t * 10 + o;
   endfunction

   // model: remaining RUN cycles until 00; display is that time rounded up to whole units
   task automatic model_step(input logic r, input logic ld, input logic st, input logic ps,
                             input logic [7:0] sv);
      m_done = 0;
      if (r) begin
         m_rem  = 0;
         m_mode = M_IDLE;
      end else if (ld && m_mode != M_RUN) begin
         m_rem  = clamp_val(sv) * T;
         m_mode = M_IDLE;
      end else if (m_mode == M_IDLE) begin
         if (st && m_rem > 0) m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
         if (ps) m_mode = M_PAUSE;
         else begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
               m_mode = M_DONE;
               m_done = 1;
            end
         end
      end else if (m_mode == M_PAUSE) begin
         if (!ps && st) m_mode = M_RUN;
      end
   endtask

   function automatic logic [9:0] exp_vec();
      int v;
      v = (m_rem + T - 1) / T;
      return {4'(v / 10), 4'(v % 10), (m_mode == M_RUN), (m_done != 0)};
   endfunction

   task automatic step(input logic r, input logic ld, input logic st, input logic ps,
                       input logic [7:0] sv);
      reset       = r;
      bus.load    = ld;
      bus.start   = st;
      bus.pause   = ps;
      bus.settime = sv;
      if (!r && !ps && bus.running) run_edges++;
      @(posedge clock);
      model_step(r, ld, st, ps, sv);
      @(negedge clock);
   endtask

   task automatic test_reset();
      bus.load = 0; bus.start = 0; bus.pause = 0; bus.settime = 8'h00;
      step(1, 0, 0, 0, 8'h00);
      step(1, 0, 1, 0, 8'h55);
      checks++;
      if ({bus.code1, bus.code2, bus.running, bus.done} !== 10'h000) begin
         errors++;
         $display("FAIL reset_state: got %h expected %h", {bus.code1, bus.code2, bus.running, bus.done}, 10'h000);
      end
      step(0, 0, 0, 0, 8'h00);
   endtask

   task automatic test_full_run();
      int n;
      n = -1;
      step(0, 1, 0, 0, 8'h12);
      checks++;
      if ({bus.code1, bus.code2} !== 8'h12) begin
         errors++;
         $display("FAIL load_12: got %h expected 12", {bus.code1, bus.code2});
      end
      step(0, 0, 1, 0, 8'h00);
      checks++;
      if (bus.running !== 1'b1) begin
         errors++;
         $display("FAIL start_running: got %b expected 1", bus.running);
      end
      for (int i = 0; i < 60 && n < 0; i++) begin
         step(0, 0, 0, 0, 8'h00);
         checks++;
         if ({bus.code1, bus.code2, bus.running, bus.done} !== exp_vec()) begin
            errors++;
            $display("FAIL full_run cycle %0d: got %h expected %h", i, {bus.code1, bus.code2, bus.running, bus.done}, exp_vec());
         end
         if (bus.done) n = i + 1;
      end
      checks++;
      if (n != 12 * T) begin
         errors++;
         $display("FAIL full_run_latency: got %0d expected %0d", n, 12 * T);
      end
      step(0, 0, 0, 0, 8'h00);
      checks++;
      if ({bus.code1, bus.code2, bus.running, bus.done} !== 10'h000) begin
         errors++;
         $display("FAIL after_done: got %h expected 000", {bus.code1, bus.code2, bus.running, bus.done});
      end
   endtask

   task automatic test_clamp_zero();
      logic [7:0] sv [3];
      logic [7:0] ex [3];
      sv = '{8'hAF, 8'h5F, 8'hA3};
      ex = '{8'h99, 8'h59, 8'h93};
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0, sv[i]);
         checks++;
         if ({bus.code1, bus.code2} !== ex[i]) begin
            errors++;
            $display("FAIL clamp %h: got %h expected %h", sv[i], {bus.code1, bus.code2}, ex[i]);
         end
      end
      step(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 1, 0, 8'h00);
         checks++;
         if ({bus.code1, bus.code2, bus.running, bus.done} !== 10'h000) begin
            errors++;
            $display("FAIL start_at_zero %0d: got %h expected 000", i, {bus.code1, bus.code2, bus.running, bus.done});
         end
      end
   endtask

   task automatic test_pause_resume();
      logic [9:0] held;
      logic       seen;
      seen = 0;
      step(0, 1, 0, 0, 8'h05);
      run_edges = 0;
      step(0, 0, 1, 0, 8'h00);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 8'h00);
      step(0, 0, 0, 1, 8'h00);
      held = {bus.code1, bus.code2, bus.running, bus.done};
      checks++;
      if (held !== exp_vec()) begin
         errors++;
         $display("FAIL pause_entry: got %h expected %h", held, exp_vec());
      end
      for (int i = 0; i < 20; i++) begin
         step(0, 0, 0, i[0], 8'h00);
         checks++;
         if ({bus.code1, bus.code2, bus.running, bus.done} !== held) begin
            errors++;
            $display("FAIL pause_hold %0d: got %h expected %h", i, {bus.code1, bus.code2, bus.running, bus.done}, held);
         end
      end
      step(0, 0, 1, 0, 8'h00);
      for (int i = 0; i < 40 && !seen; i++) begin
         step(0, 0, 0, 0, 8'h00);
         checks++;
         if ({bus.code1, bus.code2, bus.running, bus.done} !== exp_vec()) begin
            errors++;
            $display("FAIL resume cycle %0d: got %h expected %h", i, {bus.code1, bus.code2, bus.running, bus.done}, exp_vec());
         end
         seen = bus.done;
      end
      checks++;
      if (!seen || run_edges != 5 * T) begin
         errors++;
         $display("FAIL pause_total_run: got %0d (done seen %b) expected %0d", run_edges, seen, 5 * T);
      end
   endtask

   task automatic test_priority();
      step(0, 1, 0, 0, 8'h40);
      step(0, 0, 1, 0, 8'h00);
      step(0, 0, 0, 0, 8'h00);
      step(0, 0, 1, 1, 8'h00);
      checks++;
      if (bus.running !== 1'b0 || {bus.code1, bus.code2, bus.running, bus.done} !== exp_vec()) begin
         errors++;
         $display("FAIL start_pause_in_run: got %h expected %h", {bus.code1, bus.code2, bus.running, bus.done}, exp_vec());
      end
      step(0, 0, 1, 1, 8'h00);
      checks++;
      if (bus.running !== 1'b0) begin
         errors++;
         $display("FAIL start_pause_in_pause: got %b expected 0", bus.running);
      end
      step(0, 0, 1, 0, 8'h00);
      for (int i = 0; i < 6; i++) begin
         step(0, (i < 2), 0, 0, 8'h77);
         checks++;
         if ({bus.code1, bus.code2, bus.running, bus.done} !== exp_vec()) begin
            errors++;
            $display("FAIL load_in_run %0d: got %h expected %h", i, {bus.code1, bus.code2, bus.running, bus.done}, exp_vec());
         end
      end
      step(0, 0, 0, 1, 8'h00);
      step(0, 1, 1, 1, 8'h30);
      checks++;
      if ({bus.code1, bus.code2, bus.running, bus.done} !== 10'h0C0) begin
         errors++;
         $display("FAIL load_in_pause: got %h expected 0c0", {bus.code1, bus.code2, bus.running, bus.done});
      end
   endtask

   task automatic test_reset_mid_run();
      step(0, 1, 0, 0, 8'h07);
      step(0, 0, 1, 0, 8'h00);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 8'h00);
      step(1, 0, 0, 0, 8'h00);
      checks++;
      if ({bus.code1, bus.code2, bus.running, bus.done} !== 10'h000) begin
         errors++;
         $display("FAIL reset_mid_run: got %h expected 000", {bus.code1, bus.code2, bus.running, bus.done});
      end
      step(0, 0, 1, 0, 8'h00);
      step(0, 0, 0, 0, 8'h00);
      checks++;
      if ({bus.code1, bus.code2, bus.running, bus.done} !== 10'h000) begin
         errors++;
         $display("FAIL start_after_reset: got %h expected 000", {bus.code1, bus.code2, bus.running, bus.done});
      end
   endtask

   task automatic test_done_reload();
      int n;
      n = -1;
      step(0, 1, 0, 0, 8'h02);
      step(0, 0, 1, 0, 8'h00);
      for (int i = 0; i < 4 * T && m_mode != M_DONE; i++) step(0, 0, 0, 0, 8'h00);
      step(0, 0, 1, 1, 8'h00);
      checks++;
      if ({bus.code1, bus.code2, bus.running, bus.done} !== 10'h000) begin
         errors++;
         $display("FAIL start_in_done: got %h expected 000", {bus.code1, bus.code2, bus.running, bus.done});
      end
      step(0, 1, 0, 0, 8'h01);
      checks++;
      if ({bus.code1, bus.code2, bus.running, bus.done} !== 10'h004) begin
         errors++;
         $display("FAIL reload_01: got %h expected 004", {bus.code1, bus.code2, bus.running, bus.done});
      end
      step(0, 0, 1, 0, 8'h00);
      for (int i = 0; i < 3 * T && n < 0; i++) begin
         step(0, 0, 0, 0, 8'h00);
         if (bus.done) n = i + 1;
      end
      checks++;
      if (n != T) begin
         errors++;
         $display("FAIL reload_done_latency: got %0d expected %0d", n, T);
      end
   endtask

   task automatic test_random();
      logic r, ld, st, ps;
      logic [7:0] sv;
      for (int i = 0; i < 600; i++) begin
         r  = ($urandom_range(0, 63) == 0);
         ld = ($urandom_range(0, 15) == 0);
         st = ($urandom_range(0, 3) == 0);
         ps = ($urandom_range(0, 7) == 0);
         sv = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
         step(r, ld, st, ps, sv);
         checks++;
         if ({bus.code1, bus.code2, bus.running, bus.done} !== exp_vec()) begin
            errors++;
            $display("FAIL random cycle %0d: got %h expected %h", i, {bus.code1, bus.code2, bus.running, bus.done}, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_run();
      test_clamp_zero();
      test_pause_resume();
      test_priority();
      test_reset_mid_run();
      test_done_reload();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
